// File: rtl/q2_uart_io_pkg.sv
// Shared definitions for the q2 UART: register offsets, STATUS bit positions and FSM encodings.
package q2_uart_io_pkg;

  localparam logic [3:0] OFF_DATA   = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_DIV    = 4'd2;

  localparam int ST_RX_VALID     = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_RX_OVERRUN   = 3;
  localparam int ST_TX_OVERFLOW  = 4;
  localparam int ST_RX_FRAME_ERR = 5;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // RX_BREAK holds off after a framing error until the line returns high.
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

endpackage

// File: rtl/q2_sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; pushes while full and pops while empty are ignored.
module q2_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/q2_uart_io.sv
// Memory-mapped 8N1 UART on the q2 bus: register window, TX FIFO + transmitter, receiver with holding register.
module q2_uart_io
  import q2_uart_io_pkg::*;
#(
  parameter logic [11:0] BASE        = 12'hFF0,
  parameter logic [11:0] DIV_DEFAULT = 12'd433,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] abus,
  inout  wire  [11:0] dbus,
  input  logic        rdm,
  input  logic        wrm,
  output logic        sel,
  output logic        txd,
  input  logic        rxd
);

  logic [3:0]  off;
  logic        wrm_d, rdm_d, rd_data_d;
  logic        wr_evt, wr_data, wr_stat, wr_div, rd_clear;
  logic [11:0] divisor, rd_val;
  logic        rx_valid, rx_overrun, rx_frame_err, tx_overflow;
  logic [7:0]  rx_data;
  logic        fifo_full, fifo_empty, tx_empty;
  logic [7:0]  fifo_rdata;

  tx_state_t   tx_state, tx_next;
  logic [11:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick, tx_pop;

  rx_state_t   rx_state, rx_next;
  logic [11:0] rx_cnt, rx_half_m1;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_s1, rx_s2, rx_tick, rx_done, rx_ferr;

  assign off      = abus[3:0];
  assign sel      = (abus[11:4] == BASE[11:4]);
  assign wr_evt   = wrm && !wrm_d && sel;
  assign wr_data  = wr_evt && (off == OFF_DATA);
  assign wr_stat  = wr_evt && (off == OFF_STATUS);
  assign wr_div   = wr_evt && (off == OFF_DIV);
  assign rd_clear = !rdm && rdm_d && rd_data_d;
  assign tx_empty = fifo_empty && (tx_state == TX_IDLE);

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_DATA:   rd_val = {4'b0, rx_data};
      OFF_STATUS: rd_val = {6'b0, rx_frame_err, tx_overflow, rx_overrun, tx_empty, fifo_full, rx_valid};
      OFF_DIV:    rd_val = divisor;
      default:    rd_val = '0;
    endcase
  end

  assign dbus = (rdm && sel) ? rd_val : 12'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrm_d       <= 1'b0;
      rdm_d       <= 1'b0;
      rd_data_d   <= 1'b0;
      divisor     <= DIV_DEFAULT;
      tx_overflow <= 1'b0;
    end else begin
      wrm_d <= wrm;
      rdm_d <= rdm;
      if (rdm) rd_data_d <= sel && (off == OFF_DATA);
      if (wr_div) divisor <= (dbus == 12'd0) ? 12'd1 : dbus;
      if (wr_data && fifo_full)                 tx_overflow <= 1'b1;
      else if (wr_stat && dbus[ST_TX_OVERFLOW]) tx_overflow <= 1'b0;
    end
  end

  q2_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .wdata (dbus[7:0]),
    .pop   (tx_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Transmitter: every state lasts divisor+1 clocks; the STOP exit chains straight into the next START.
  assign tx_tick = (tx_cnt == 12'd0);

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    unique case (tx_state)
      TX_IDLE:  if (!fifo_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) begin
                  if (!fifo_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
                  else tx_next = TX_IDLE;
                end
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_pop || tx_tick) ? divisor : tx_cnt - 12'd1;
      if (tx_state != TX_DATA) tx_bit <= '0;
      else if (tx_tick)        tx_bit <= tx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop)                           tx_shift <= fifo_rdata;
    else if (tx_state == TX_DATA && tx_tick) tx_shift <= {1'b0, tx_shift[7:1]};
  end

  always_comb begin
    unique case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_shift[0];
      default:  txd = 1'b1;
    endcase
  end

  // Receiver: the first check lands mid start bit, later samples follow one bit period apart.
  assign rx_half_m1 = 12'((({1'b0, divisor} + 13'd1) >> 1) - 13'd1);
  assign rx_tick    = (rx_cnt == 12'd0);
  assign rx_done    = (rx_state == RX_STOP) && rx_tick && rx_s2;
  assign rx_ferr    = (rx_state == RX_STOP) && rx_tick && !rx_s2;

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (!rx_s2) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_s2) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) rx_cnt <= rx_half_m1;
      else if (rx_tick)        rx_cnt <= divisor;
      else                     rx_cnt <= rx_cnt - 12'd1;
      if (rx_state != RX_DATA) rx_bit <= '0;
      else if (rx_tick)        rx_bit <= rx_bit + 3'd1;
      if (rx_done) rx_data <= rx_shift;
      // A completing byte beats a concurrent DATA-read clear and is not an overrun.
      if (rx_done)       rx_valid <= 1'b1;
      else if (rd_clear) rx_valid <= 1'b0;
      if (rx_done && rx_valid && !rd_clear)   rx_overrun <= 1'b1;
      else if (wr_stat && dbus[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
      if (rx_ferr)                               rx_frame_err <= 1'b1;
      else if (wr_stat && dbus[ST_RX_FRAME_ERR]) rx_frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[7:1]};
  end

endmodule

// File: tb/tb_q2_uart_io.sv
// Bench for q2_uart_io: random bus/serial stimulus, a frame-decoding TX monitor with a byte scoreboard, and a register-level model.
module tb_q2_uart_io;

  localparam logic [11:0] BASE = 12'hFF0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] abus = BASE;
  logic        rdm = 1'b0;
  logic        wrm = 1'b0;
  logic        rxd = 1'b1;
  logic        sel, txd;
  wire  [11:0] dbus;
  logic        drv_en = 1'b0;
  logic [11:0] drv_val = '0;

  assign dbus = drv_en ? drv_val : 12'bz;

  q2_uart_io #(.BASE(BASE), .DIV_DEFAULT(12'd433), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .abus(abus), .dbus(dbus), .rdm(rdm), .wrm(wrm),
    .sel(sel), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] tx_q[$];
  int         starts[$];
  int         cur_div = 433;
  bit         m_valid, m_ovr, m_ferr, m_tx_ovf;
  logic [7:0] m_data;

  function automatic logic [11:0] exp_status(input bit full, input bit empty);
    return {6'b0, m_ferr, m_tx_ovf, m_ovr, empty, full, m_valid};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", name, act, want);
    end
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [11:0] val);
    @(negedge clk);
    abus = BASE | {8'h0, off}; drv_val = val; drv_en = 1'b1; wrm = 1'b1;
    @(negedge clk);
    wrm = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [11:0] val);
    @(negedge clk);
    abus = BASE | {8'h0, off}; rdm = 1'b1;
    @(posedge clk);
    @(negedge clk);
    val = dbus; rdm = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [3:0] off, input logic [11:0] want);
    logic [11:0] v;
    bus_read(off, v);
    chk(name, v, want);
  endtask

  task automatic set_div(input logic [11:0] v);
    bus_write(4'd2, v);
    cur_div = (v == 12'd0) ? 1 : int'(v);
  endtask

  task automatic tx_send(input logic [7:0] b, input bit accept);
    bus_write(4'd0, {4'h0, b});
    if (accept) tx_q.push_back(b);
    else m_tx_ovf = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    int bp;
    bp = cur_div + 1;
    @(negedge clk); rxd = 1'b0;
    repeat (bp - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rxd = b[i];
      repeat (bp - 1) @(negedge clk);
    end
    @(negedge clk); rxd = stop;
    repeat (bp - 1) @(negedge clk);
    @(negedge clk); rxd = 1'b1;
    repeat (bp + 4) @(negedge clk);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic read_data(input string name);
    check_reg(name, 4'd0, {4'h0, m_data});
    m_valid = 1'b0;
  endtask

  task automatic wait_tx_drain(input string name);
    int n;
    int limit;
    n = 0;
    limit = 60 * (cur_div + 1) + 100;
    while (tx_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d bytes still unsent after %0d cycles, required 0", name, tx_q.size(), limit);
      tx_q.delete();
    end
    repeat (2 * (cur_div + 1)) @(negedge clk);
  endtask

  // TX monitor: decode each frame from txd at mid-bit and compare with the byte scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && txd == 1'b0) begin
        int         bp;
        bit         ok;
        bit         framing;
        logic [7:0] b;
        logic [7:0] want;
        bp = cur_div + 1;
        ok = 1'b1;
        starts.push_back(cyc);
        repeat (bp / 2) begin @(negedge clk); if (!rst) ok = 1'b0; end
        framing = (txd == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (bp) begin @(negedge clk); if (!rst) ok = 1'b0; end
          b[i] = txd;
        end
        repeat (bp) begin @(negedge clk); if (!rst) ok = 1'b0; end
        framing = framing && (txd == 1'b1);
        if (ok) begin
          checks++;
          if (tx_q.size() == 0) begin
            errors++;
            $display("FAIL tx_frame: got unexpected byte %02h, required no frame", b);
          end else begin
            want = tx_q.pop_front();
            if (b !== want || !framing) begin
              errors++;
              $display("FAIL tx_frame: got %02h (framing ok=%0d) expected %02h with valid start/stop", b, framing, want);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] v;
    logic [7:0]  b, b2;
    int          low_cnt;

    // Reset state
    repeat (3) @(negedge clk);
    chk("txd_in_reset", {11'h0, txd}, 12'h001);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("txd_idle", {11'h0, txd}, 12'h001);
    check_reg("status_reset", 4'd1, exp_status(0, 1));
    check_reg("div_reset", 4'd2, 12'd433);

    // Divisor boundary: zero stores one
    set_div(12'd0);
    check_reg("div_zero", 4'd2, 12'd1);
    set_div(12'd3);
    check_reg("div_3", 4'd2, 12'd3);

    // Directed 0xA5 frame: start + four zero data bits low, 4 clocks each
    tx_send(8'hA5, 1'b1);
    low_cnt = 0;
    repeat (48) begin @(negedge clk); if (txd == 1'b0) low_cnt++; end
    chk("a5_low_clocks", 12'(low_cnt), 12'd20);
    wait_tx_drain("a5_drain");
    check_reg("a5_tx_empty", 4'd1, exp_status(0, 1));

    // Random TX bytes at random divisors
    for (int k = 0; k < 5; k++) begin
      set_div(12'($urandom_range(2, 6)));
      b = 8'($urandom);
      tx_send(b, 1'b1);
      check_reg("tx_busy_status", 4'd1, exp_status(0, 0));
      wait_tx_drain("tx_rand_drain");
      check_reg("tx_done_status", 4'd1, exp_status(0, 1));
    end

    // Back-to-back writes fill the FIFO, the sixth overflows
    set_div(12'd3);
    starts.delete();
    for (int k = 0; k < 5; k++) tx_send(8'($urandom), 1'b1);
    check_reg("fifo_full", 4'd1, exp_status(1, 0));
    tx_send(8'($urandom), 1'b0);
    check_reg("fifo_overflow", 4'd1, exp_status(1, 0));
    bus_write(4'd1, 12'h010);
    m_tx_ovf = 1'b0;
    check_reg("overflow_clear", 4'd1, exp_status(1, 0));
    wait_tx_drain("b2b_drain");
    chk("b2b_frames", 12'(starts.size()), 12'd5);
    for (int k = 0; k + 1 < starts.size(); k++)
      chk("b2b_gap", 12'(starts[k+1] - starts[k]), 12'd40);
    check_reg("b2b_idle", 4'd1, exp_status(0, 1));

    // RX: directed 0x3C
    send_rx(8'h3C, 1'b1);
    check_reg("rx_valid_set", 4'd1, exp_status(0, 1));
    read_data("rx_data_3c");
    check_reg("rx_valid_clear", 4'd1, exp_status(0, 1));

    // RX overrun: two frames without a read
    set_div(12'($urandom_range(2, 6)));
    b  = 8'($urandom);
    b2 = 8'($urandom);
    send_rx(b, 1'b1);
    send_rx(b2, 1'b1);
    check_reg("rx_overrun_set", 4'd1, exp_status(0, 1));
    read_data("rx_data_second");
    check_reg("rx_overrun_held", 4'd1, exp_status(0, 1));
    bus_write(4'd1, 12'h008);
    m_ovr = 1'b0;
    check_reg("rx_overrun_clear", 4'd1, exp_status(0, 1));

    // Framing error and its clear
    set_div(12'd3);
    send_rx(8'($urandom), 1'b0);
    check_reg("rx_frame_err", 4'd1, exp_status(0, 1));
    bus_write(4'd1, 12'h020);
    m_ferr = 1'b0;
    check_reg("rx_frame_err_clear", 4'd1, exp_status(0, 1));

    // One-clock glitch is rejected, then a real frame still decodes
    @(negedge clk); rxd = 1'b0;
    @(negedge clk); rxd = 1'b1;
    repeat (30) @(negedge clk);
    check_reg("rx_glitch", 4'd1, exp_status(0, 1));
    for (int k = 0; k < 3; k++) begin
      send_rx(8'($urandom), 1'b1);
      read_data("rx_data_rand");
    end

    // Unmapped offsets read zero and ignore writes
    bus_write(4'd3, 12'h055);
    check_reg("off3_read", 4'd3, 12'h000);
    check_reg("div_after_off3", 4'd2, 12'd3);

    // Asynchronous reset in the middle of a data bit
    tx_send(8'h00, 1'b1);
    repeat (15) @(negedge clk);
    chk("txd_data_low", {11'h0, txd}, 12'h000);
    #2 rst = 1'b0;
    #1 chk("txd_reset_abort", {11'h0, txd}, 12'h001);
    tx_q.delete();
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_tx_ovf = 0; m_data = '0;
    cur_div = 433;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reg("status_after_reset", 4'd1, exp_status(0, 1));
    check_reg("div_after_reset", 4'd2, 12'd433);
    check_reg("rx_data_after_reset", 4'd0, 12'h000);

    // Address outside the window
    @(negedge clk);
    abus = BASE - 12'd1; rdm = 1'b1;
    @(negedge clk);
    chk("sel_outside", {11'h0, sel}, 12'h000);
    rdm = 1'b0;
    abus = BASE | 12'h003;
    @(negedge clk);
    chk("sel_inside", {11'h0, sel}, 12'h001);
    repeat (60) @(negedge clk);
    chk("txd_final_idle", {11'h0, txd}, 12'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
